fan_speed_sched: RTL

- Front-end controller that sequences the 2-bit fan speed code consumed by the 100 kHz PWM generator (levels 0..3 = 0/30/60/90 % duty).
- Turns one-cycle button pulses (speed, timer, off) into a target level.
- Soft-ramps the delivered level one step at a time, and runs an auto-off countdown timer.
- Sits between the button debounce/edge logic and the PWM generator; all in the 100 kHz domain.

---
 rtl/fan_ctrl_pkg.sv | 27 ++
 rtl/fan_tick_div.sv | 27 ++
 rtl/fan_speed_sched.sv | 116 +++++++++++
 3 files changed

// File: rtl/fan_ctrl_pkg.sv
// fan_ctrl_pkg: shared state encoding, speed levels and timer tables for the fan speed scheduler
package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] SPD_OFF  = 2'd0;
    localparam logic [1:0] SPD_LOW  = 2'd1;
    localparam logic [1:0] SPD_MID  = 2'd2;
    localparam logic [1:0] SPD_HIGH = 2'd3;

    // Timer units loaded for timer select 0..3
    localparam logic [3:0][2:0] TIMER_LOAD = {3'd5, 3'd3, 3'd1, 3'd0};

    // Speed button order 0->1->2->3->1; level 0 is only re-entered by off/expiry
    function automatic logic [1:0] next_speed(input logic [1:0] s);
        return (s == SPD_HIGH) ? SPD_LOW : s + 2'd1;
    endfunction

    function automatic logic [1:0] next_tsel(input logic [1:0] t);
        return t + 2'd1;
    endfunction

endpackage

// File: rtl/fan_tick_div.sv
// fan_tick_div: clearable prescaler that pulses tick while enabled at count MOD-1 and wraps to 0
module fan_tick_div #(
    parameter int CNT_W = 23,
    parameter int MOD   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over counting; the count is held while disabled
    always_comb begin
        tick  = en && (cnt_q == CNT_W'(MOD - 1));
        cnt_d = (clr || tick) ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Prescaler register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fan_speed_sched.sv
// fan_speed_sched: button-driven target level, one-step-at-a-time soft ramp and auto-off timer
module fan_speed_sched
    import fan_ctrl_pkg::*;
#(
    parameter int RAMP_TICKS = 50000,
    parameter int TIMER_UNIT = 6000000,
    parameter int CNT_W      = 23
) (
    input  logic       i_100kHz,
    input  logic       i_rst,
    input  logic       i_btn_speed,
    input  logic       i_btn_timer,
    input  logic       i_btn_off,
    output logic [1:0] o_FANspeed,
    output logic [1:0] o_target,
    output logic [2:0] o_timer_left,
    output logic       o_timer_done,
    output logic       o_ramping
);

    state_t     state_q, state_d;
    logic [1:0] target_q, target_d;
    logic [1:0] speed_q, speed_d;
    logic [1:0] tsel_q, tsel_d;
    logic [2:0] timer_left_q, timer_left_d;
    logic       done_q, done_d;
    logic       ramping_q, ramping_d;
    logic       expire, tmr_press, timer_clr, timer_tick;
    logic       ramp_clr, ramp_en, ramp_tick;

    fan_tick_div #(.CNT_W(CNT_W), .MOD(TIMER_UNIT)) u_timer_div (
        .clk (i_100kHz),
        .rst (i_rst),
        .clr (timer_clr),
        .en  (timer_left_q != 3'd0),
        .tick(timer_tick)
    );

    fan_tick_div #(.CNT_W(CNT_W), .MOD(RAMP_TICKS)) u_ramp_div (
        .clk (i_100kHz),
        .rst (i_rst),
        .clr (ramp_clr),
        .en  (ramp_en),
        .tick(ramp_tick)
    );

    // Target and timer: off beats expiry beats the buttons; timer press checks the pre-update target
    always_comb begin
        expire       = timer_tick && (timer_left_q == 3'd1);
        tmr_press    = i_btn_timer && (target_q != SPD_OFF) && !i_btn_off && !expire;
        timer_clr    = i_btn_off || tmr_press;
        target_d     = (i_btn_off || expire) ? SPD_OFF :
                       i_btn_speed ? next_speed(target_q) : target_q;
        tsel_d       = (i_btn_off || expire) ? 2'd0 :
                       tmr_press ? next_tsel(tsel_q) : tsel_q;
        timer_left_d = i_btn_off ? 3'd0 :
                       tmr_press ? TIMER_LOAD[next_tsel(tsel_q)] :
                       timer_tick ? timer_left_q - 3'd1 : timer_left_q;
        done_d       = expire && !i_btn_off;
    end

    // Ramp FSM: entry follows the incoming target so the first step lands RAMP_TICKS after it changes
    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        ramp_clr = 1'b0;
        ramp_en  = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (target_d != speed_q) begin
                    state_d  = RAMP;
                    ramp_clr = 1'b1;
                end
            end
            RAMP: begin
                if (speed_q == target_q) begin
                    if (target_d == speed_q) state_d = (speed_q == SPD_OFF) ? IDLE : HOLD;
                    else                     ramp_clr = 1'b1;
                end else begin
                    ramp_en = 1'b1;
                    if (ramp_tick) speed_d = (target_q > speed_q) ? speed_q + 2'd1 : speed_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        ramping_d = (state_d == RAMP);
    end

    // All state and outputs registered
    always_ff @(posedge i_100kHz or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            target_q     <= SPD_OFF;
            speed_q      <= SPD_OFF;
            tsel_q       <= 2'd0;
            timer_left_q <= 3'd0;
            done_q       <= 1'b0;
            ramping_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            speed_q      <= speed_d;
            tsel_q       <= tsel_d;
            timer_left_q <= timer_left_d;
            done_q       <= done_d;
            ramping_q    <= ramping_d;
        end
    end

    assign o_FANspeed   = speed_q;
    assign o_target     = target_q;
    assign o_timer_left = timer_left_q;
    assign o_timer_done = done_q;
    assign o_ramping    = ramping_q;

endmodule
